// File: rtl/dual_slope_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_slope_adc_pkg
// Brief    : Shared types and constants for the multi-channel dual-slope ADC.
// Revision : 1.0 - initial release
// ============================================================================
package dual_slope_adc_pkg;

    typedef enum logic [1:0] {
        S_SETTLE  = 2'd0,
        S_RUNUP   = 2'd1,
        S_RUNDOWN = 2'd2
    } adc_state_t;

    localparam int CMP_SYNC_LAT = 2;

    // Mux select width; a single channel still needs a 1-bit port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dual_slope_cmp_sync.sv
`default_nettype none
// ============================================================================
// Module   : dual_slope_cmp_sync
// Brief    : Multi-flop synchronizer for the asynchronous comparator output.
// Revision : 1.0 - initial release
// ============================================================================
module dual_slope_cmp_sync
    import dual_slope_adc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [CMP_SYNC_LAT-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[CMP_SYNC_LAT-2:0], d_i};
        end
    end

    assign q_o = sync_q[CMP_SYNC_LAT-1];

endmodule
`default_nettype wire

// File: rtl/dual_slope_adc_mc.sv
`default_nettype none
// ============================================================================
// Module   : dual_slope_adc_mc
// Brief    : Multi-channel dual-slope ADC sequencer (settle / run-up / run-down).
//            Optional macro DUAL_SLOPE_ADC_CMP_SYNC_EN synchronizes is_neg_v.
// Revision : 1.0 - initial release
// ============================================================================
module dual_slope_adc_mc
    import dual_slope_adc_pkg::*;
#(
    parameter  int CNT_W         = 8,
    parameter  int N_CH          = 2,
    parameter  int SETTLE_CYCLES = 16,
    localparam int CH_W          = ch_width(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             is_neg_v,
    output logic             select_v_ref,
    output logic             int_discharge,
    output logic [CH_W-1:0]  ch_sel,
    output logic [CNT_W-1:0] digit_val,
    output logic [CH_W-1:0]  data_ch,
    output logic             data_valid,
    output logic             overflow
);

    localparam int C_SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int C_CTR_W = (CNT_W > C_SET_W) ? CNT_W : C_SET_W;
    localparam logic [C_CTR_W-1:0] C_RUN_LAST    = C_CTR_W'({CNT_W{1'b1}});
    localparam logic [C_CTR_W-1:0] C_SETTLE_LAST = C_CTR_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_W-1:0]    C_CH_LAST     = CH_W'(N_CH - 1);

    adc_state_t         state_q, state_d;
    logic [C_CTR_W-1:0] counter_q, counter_d;
    logic               sel_q, sel_d;
    logic               dis_q, dis_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]   digit_q, digit_d;
    logic [CH_W-1:0]    data_ch_q, data_ch_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;

    logic               w_cmp_neg;
    logic [C_CTR_W-1:0] w_result;

`ifdef DUAL_SLOPE_ADC_CMP_SYNC_EN
    dual_slope_cmp_sync u_cmp_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (is_neg_v),
        .q_o   (w_cmp_neg)
    );
    // The count overshoots by the synchronizer depth; remove it, floor at zero.
    assign w_result = (counter_q < C_CTR_W'(CMP_SYNC_LAT)) ? '0
                    : counter_q - C_CTR_W'(CMP_SYNC_LAT);
`else
    assign w_cmp_neg = is_neg_v;
    assign w_result  = counter_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_SETTLE;
            counter_q <= '0;
            sel_q     <= 1'b0;
            dis_q     <= 1'b1;
            ch_q      <= '0;
            digit_q   <= '0;
            data_ch_q <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            sel_q     <= sel_d;
            dis_q     <= dis_d;
            ch_q      <= ch_d;
            digit_q   <= digit_d;
            data_ch_q <= data_ch_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        logic done;
        done      = 1'b0;
        state_d   = state_q;
        counter_d = counter_q;
        sel_d     = sel_q;
        dis_d     = dis_q;
        ch_d      = ch_q;
        digit_d   = digit_q;
        data_ch_d = data_ch_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;

        case (state_q)
            S_SETTLE: begin
                dis_d = 1'b1;
                sel_d = 1'b0;
                // Counter parks on its last value while enable is low.
                if (counter_q == C_SETTLE_LAST) begin
                    if (enable) begin
                        counter_d = '0;
                        dis_d     = 1'b0;
                        state_d   = S_RUNUP;
                    end
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            S_RUNUP: begin
                sel_d = 1'b0;
                if (counter_q == C_RUN_LAST) begin
                    counter_d = '0;
                    sel_d     = 1'b1;
                    state_d   = S_RUNDOWN;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            S_RUNDOWN: begin
                if (!w_cmp_neg) begin
                    digit_d = w_result[CNT_W-1:0];
                    ovf_d   = 1'b0;
                    done    = 1'b1;
                end else if (counter_q == C_RUN_LAST) begin
                    digit_d = '1;
                    ovf_d   = 1'b1;
                    done    = 1'b1;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
                if (done) begin
                    data_ch_d = ch_q;
                    valid_d   = 1'b1;
                    sel_d     = 1'b0;
                    dis_d     = 1'b1;
                    counter_d = '0;
                    ch_d      = (ch_q == C_CH_LAST) ? '0 : ch_q + 1'b1;
                    state_d   = S_SETTLE;
                end
            end
            default: begin
                state_d = S_SETTLE;
            end
        endcase
    end

    assign select_v_ref  = sel_q;
    assign int_discharge = dis_q;
    assign ch_sel        = ch_q;
    assign digit_val     = digit_q;
    assign data_ch       = data_ch_q;
    assign data_valid    = valid_q;
    assign overflow      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_slope_adc_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_slope_adc_mc
// Brief    : Self-checking bench for dual_slope_adc_mc (N_CH=3 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_slope_adc_mc;

    localparam int CNT_W  = 8;
    localparam int N_CH   = 3;
    localparam int SETTLE = 16;
    localparam int CH_W   = 2;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             is_neg_v = 1'b1;
    logic             select_v_ref, int_discharge, data_valid, overflow;
    logic [CH_W-1:0]  ch_sel, data_ch;
    logic [CNT_W-1:0] digit_val;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ch  = 0;

    always #5 clk = ~clk;

    dual_slope_adc_mc #(
        .CNT_W         (CNT_W),
        .N_CH          (N_CH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .is_neg_v      (is_neg_v),
        .select_v_ref  (select_v_ref),
        .int_discharge (int_discharge),
        .ch_sel        (ch_sel),
        .digit_val     (digit_val),
        .data_ch       (data_ch),
        .data_valid    (data_valid),
        .overflow      (overflow)
    );

    // Reference model: result is the run-down length, saturating at all ones.
    function automatic int model_digit(input int k);
        return (k < 0 || k >= MAXV) ? MAXV : k;
    endfunction

    function automatic bit model_ovf(input int k);
        return (k < 0 || k >= MAXV);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        exp_ch = 0;
    endtask

    task automatic wait_select();
        bit seen = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (select_v_ref) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_select: select_v_ref got 0, required 1 within 700 cycles");
        end
    endtask

    // Starts at the negedge where select_v_ref is first seen high; k<0 = stuck.
    task automatic drive_rundown(input int k);
        bit seen = 1'b0;
        is_neg_v = 1'b1;
        if (k >= 0) begin
            repeat (k) @(negedge clk);
            is_neg_v = 1'b0;
        end
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (data_valid) begin
                seen = 1'b1;
                break;
            end
        end
        is_neg_v = 1'b1;
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_valid: data_valid got 0, required 1 within 700 cycles");
        end
    endtask

    task automatic run_conv(input int k);
        wait_select();
        drive_rundown(k);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({select_v_ref, int_discharge, data_valid, overflow} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got sel/dis/vld/ovf=%b required 0100",
                     {select_v_ref, int_discharge, data_valid, overflow});
        end
        n_tests++;
        if ({ch_sel, data_ch, digit_val} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got ch_sel=%0d data_ch=%0d digit=%0d required 0,0,0",
                     ch_sel, data_ch, digit_val);
        end
    endtask

    task automatic test_runup_timing();
        int c_dis = 0;
        int c_run = 0;
        enable = 1'b1;
        do_reset();
        do begin
            @(negedge clk);
            c_dis++;
        end while (int_discharge && c_dis < 100);
        n_tests++;
        if (c_dis !== SETTLE) begin
            n_fail++;
            $display("FAIL settle_len: got %0d cycles required %0d", c_dis, SETTLE);
        end
        do begin
            @(negedge clk);
            c_run++;
        end while (!select_v_ref && c_run < 600);
        n_tests++;
        if (c_run !== MAXV + 1) begin
            n_fail++;
            $display("FAIL runup_len: got %0d cycles required %0d", c_run, MAXV + 1);
        end
    endtask

    // Continues from the run-down entered at the end of test_runup_timing.
    task automatic test_normal();
        int pulses = 0;
        drive_rundown(37);
        n_tests++;
        if (digit_val !== CNT_W'(model_digit(37)) || overflow !== model_ovf(37) ||
            data_ch !== CH_W'(exp_ch)) begin
            n_fail++;
            $display("FAIL normal: got digit=%0d ovf=%0d ch=%0d required %0d,%0d,%0d",
                     digit_val, overflow, data_ch, model_digit(37), model_ovf(37), exp_ch);
        end
        exp_ch = (exp_ch + 1) % N_CH;
        n_tests++;
        if (ch_sel !== CH_W'(exp_ch)) begin
            n_fail++;
            $display("FAIL normal_chsel: got %0d required %0d", ch_sel, exp_ch);
        end
        repeat (20) begin
            @(negedge clk);
            if (data_valid) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL valid_pulse: got %0d extra valid cycles required 0", pulses);
        end
    endtask

    task automatic test_overflow();
        int ks[2] = '{-1, 10};
        foreach (ks[i]) begin
            run_conv(ks[i]);
            n_tests++;
            if (digit_val !== CNT_W'(model_digit(ks[i])) || overflow !== model_ovf(ks[i]) ||
                data_ch !== CH_W'(exp_ch)) begin
                n_fail++;
                $display("FAIL overflow[%0d]: got digit=%0d ovf=%0d ch=%0d required %0d,%0d,%0d",
                         i, digit_val, overflow, data_ch, model_digit(ks[i]),
                         model_ovf(ks[i]), exp_ch);
            end
            exp_ch = (exp_ch + 1) % N_CH;
        end
    endtask

    task automatic test_rotation();
        int ks[4] = '{5, 6, 7, 8};
        int rk;
        do_reset();
        foreach (ks[i]) begin
            run_conv(ks[i]);
            n_tests++;
            if (data_ch !== CH_W'(exp_ch) || digit_val !== CNT_W'(ks[i])) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got (%0d,%0d) required (%0d,%0d)",
                         i, data_ch, digit_val, exp_ch, ks[i]);
            end
            exp_ch = (exp_ch + 1) % N_CH;
        end
        for (int i = 0; i < 6; i++) begin
            rk = int'($urandom_range(0, 200));
            run_conv(rk);
            n_tests++;
            if (data_ch !== CH_W'(exp_ch) || digit_val !== CNT_W'(model_digit(rk)) ||
                overflow !== model_ovf(rk)) begin
                n_fail++;
                $display("FAIL random[%0d] k=%0d: got ch=%0d digit=%0d ovf=%0d required %0d,%0d,%0d",
                         i, rk, data_ch, digit_val, overflow, exp_ch, model_digit(rk),
                         model_ovf(rk));
            end
            exp_ch = (exp_ch + 1) % N_CH;
        end
    endtask

    task automatic test_enable();
        int bad = 0;
        wait_select();
        enable = 1'b0;
        drive_rundown(12);
        n_tests++;
        if (digit_val !== 8'd12 || data_ch !== CH_W'(exp_ch)) begin
            n_fail++;
            $display("FAIL enable_drop: got digit=%0d ch=%0d required 12,%0d",
                     digit_val, data_ch, exp_ch);
        end
        exp_ch = (exp_ch + 1) % N_CH;
        repeat (SETTLE + 30) begin
            @(negedge clk);
            if (!int_discharge || select_v_ref || data_valid) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL enable_hold: got %0d cycles out of settle required 0", bad);
        end
        enable = 1'b1;
        @(negedge clk);
        n_tests++;
        if (int_discharge !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_resume: got int_discharge=%0d required 0", int_discharge);
        end
    endtask

    task automatic test_reset_mid();
        int ks[2] = '{37, 0};
        wait_select();
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({select_v_ref, int_discharge, data_valid, overflow} !== 4'b0100 ||
            {ch_sel, data_ch, digit_val} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got sel=%0d dis=%0d vld=%0d ovf=%0d ch=%0d dch=%0d digit=%0d required 0,1,0,0,0,0,0",
                     select_v_ref, int_discharge, data_valid, overflow, ch_sel, data_ch, digit_val);
        end
        reset  = 1'b0;
        exp_ch = 0;
        foreach (ks[i]) begin
            run_conv(ks[i]);
            n_tests++;
            if (digit_val !== CNT_W'(ks[i]) || data_ch !== CH_W'(exp_ch) || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL after_reset[%0d]: got digit=%0d ch=%0d ovf=%0d required %0d,%0d,0",
                         i, digit_val, data_ch, overflow, ks[i], exp_ch);
            end
            exp_ch = (exp_ch + 1) % N_CH;
        end
    endtask

    initial begin
        test_reset();
        test_runup_timing();
        test_normal();
        test_overflow();
        test_rotation();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
